// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: RV32M op encodings,
// controller states and small op-decoding helpers.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    DIV_OP  = 2'b00,
    DIVU_OP = 2'b01,
    REM_OP  = 2'b10,
    REMU_OP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == DIV_OP) || (op == REM_OP);
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return (op == REM_OP) || (op == REMU_OP);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the reservation station and the divider.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4
);
  logic                 flush;
  logic                 start;
  op_e                  op;
  logic [WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]     divisor;
  logic [TAG_WIDTH-1:0] tag_in;
  logic                 busy;
  logic                 valid;
  logic [WIDTH-1:0]     result;
  logic [TAG_WIDTH-1:0] tag_out;

  modport master (
    output flush, start, op, dividend, divisor, tag_in,
    input  busy, valid, result, tag_out
  );

  modport slave (
    input  flush, start, op, dividend, divisor, tag_in,
    output busy, valid, result, tag_out
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// does not borrow.
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  // The shifted remainder keeps R's old MSB so full-range unsigned divisors
  // work; since R < D the difference fits and diff[WIDTH] is the borrow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {r, q_msb};
  assign diff    = shifted - {1'b0, d};
  assign q_bit   = ~diff[WIDTH];
  assign r_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a
// start/busy handshake, tag passthrough and flush support.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  state_e               state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     rem_r, quo, den, res_q;
  op_e                  op_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 q_neg, r_neg;
  logic [WIDTH-1:0]     step_r;
  logic                 step_q;

  logic accept, in_signed, in_rem, div_zero, overflow;

  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign in_signed = op_is_signed(bus.op);
  assign in_rem    = op_is_rem(bus.op);
  assign div_zero  = (bus.divisor == '0);
  assign overflow  = in_signed && (bus.dividend == MIN_NEG) && (bus.divisor == ALL_ONES);

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (rem_r),
    .q_msb  (quo[WIDTH-1]),
    .d      (den),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  // Controller state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; flush overrides everything.
  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (div_zero || overflow) ? DONE : CALC;
      CALC: if (cnt == '0) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (bus.flush) next_state = IDLE;
  end

  // Operand capture, iteration and sign fix-up.
  // NOTE: these are a handful of ordinary flops, not a memory array, so they
  // all get a reset value; it keeps reset behaviour fully deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_r <= '0;
      quo   <= '0;
      den   <= '0;
      res_q <= '0;
      op_q  <= DIV_OP;
      tag_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= bus.op;
          tag_q <= bus.tag_in;
          q_neg <= in_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          r_neg <= in_signed & bus.dividend[WIDTH-1];
          rem_r <= '0;
          quo   <= (in_signed && bus.dividend[WIDTH-1]) ? negate(bus.dividend) : bus.dividend;
          den   <= (in_signed && bus.divisor[WIDTH-1])  ? negate(bus.divisor)  : bus.divisor;
          cnt   <= CNT_W'(WIDTH-1);
          if (div_zero)      res_q <= in_rem ? bus.dividend : ALL_ONES;
          else if (overflow) res_q <= in_rem ? '0 : bus.dividend;
        end
        CALC: begin
          rem_r <= step_r;
          quo   <= {quo[WIDTH-2:0], step_q};
          cnt   <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (op_is_rem(op_q)) res_q <= r_neg ? negate(rem_r) : rem_r;
          else                 res_q <= q_neg ? negate(quo) : quo;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: busy tracks the upcoming state, valid pulses once
  // after DONE and result/tag_out hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy    <= 1'b0;
      bus.valid   <= 1'b0;
      bus.result  <= '0;
      bus.tag_out <= '0;
    end else begin
      bus.busy  <= (next_state != IDLE);
      bus.valid <= (state == DONE) && !bus.flush;
      if ((state == DONE) && !bus.flush) begin
        bus.result  <= res_q;
        bus.tag_out <= tag_q;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, hand-written
// flush/reset/busy sequences and a bounded random sweep against a model.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int NORMAL_LAT  = 34;
  localparam int SPECIAL_LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus ();

  seq_divider #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: RISC-V semantics via SV integer division.
  function automatic logic [31:0] ref_model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    logic rem;
    rem = (op == REM_OP) || (op == REMU_OP);
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (op == DIV_OP || op == REM_OP) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
      return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input op_e op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return SPECIAL_LAT;
    if ((op == DIV_OP || op == REM_OP) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return SPECIAL_LAT;
    return NORMAL_LAT;
  endfunction

  // Issue one op and wait (bounded) for its valid pulse; lat is the number of
  // rising edges after the accepting edge, -1 if none arrived.
  task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output logic [31:0] res,
                        output logic [3:0] tg, output int lat);
    @(negedge clk);
    bus.op = op; bus.dividend = a; bus.divisor = b; bus.tag_in = tag; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1; res = '0; tg = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        lat = k; res = bus.result; tg = bus.tag_out;
        break;
      end
    end
  endtask

  task automatic expect_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] res, held;
    logic [3:0]  tg;
    int          lat;

    bus.flush = 1'b0; bus.start = 1'b0; bus.op = DIV_OP;
    bus.dividend = '0; bus.divisor = '0; bus.tag_in = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_valid",   32'(bus.valid),   32'd0);
    check("rst_result",  bus.result,       32'd0);
    check("rst_tag_out", 32'(bus.tag_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors.
    vecs.push_back('{DIVU_OP, 32'd100,        32'd7,          4'd3,  32'd14,         NORMAL_LAT});
    vecs.push_back('{REMU_OP, 32'd100,        32'd7,          4'd4,  32'd2,          NORMAL_LAT});
    vecs.push_back('{DIV_OP,  32'hFFFF_FFF9,  32'd2,          4'd5,  32'hFFFF_FFFD,  NORMAL_LAT});
    vecs.push_back('{REM_OP,  32'hFFFF_FFF9,  32'd2,          4'd6,  32'hFFFF_FFFF,  NORMAL_LAT});
    vecs.push_back('{REM_OP,  32'd7,          32'hFFFF_FFFE,  4'd7,  32'd1,          NORMAL_LAT});
    vecs.push_back('{DIVU_OP, 32'd5,          32'd0,          4'd8,  32'hFFFF_FFFF,  SPECIAL_LAT});
    vecs.push_back('{REM_OP,  32'd5,          32'd0,          4'd9,  32'd5,          SPECIAL_LAT});
    vecs.push_back('{DIV_OP,  32'h8000_0000,  32'hFFFF_FFFF,  4'd10, 32'h8000_0000,  SPECIAL_LAT});
    vecs.push_back('{REM_OP,  32'h8000_0000,  32'hFFFF_FFFF,  4'd11, 32'd0,          SPECIAL_LAT});
    vecs.push_back('{DIV_OP,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  4'd12, 32'd14,         NORMAL_LAT});
    vecs.push_back('{REM_OP,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  4'd13, 32'hFFFF_FFFE,  NORMAL_LAT});
    vecs.push_back('{DIVU_OP, 32'hFFFF_FFFF,  32'd1,          4'd14, 32'hFFFF_FFFF,  NORMAL_LAT});
    vecs.push_back('{REMU_OP, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  4'd15, 32'd1,          NORMAL_LAT});
    vecs.push_back('{DIVU_OP, 32'h8000_0000,  32'd3,          4'd1,  32'h2AAA_AAAA,  NORMAL_LAT});
    vecs.push_back('{REMU_OP, 32'h8000_0000,  32'd3,          4'd2,  32'd2,          NORMAL_LAT});
    vecs.push_back('{DIV_OP,  32'h8000_0000,  32'd2,          4'd0,  32'hC000_0000,  NORMAL_LAT});
    vecs.push_back('{DIV_OP,  32'd0,          32'd5,          4'd3,  32'd0,          NORMAL_LAT});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, res, tg, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), 32'(tg), 32'(vecs[i].tag));
      check($sformatf("vec%0d_busy_low_at_valid", i), 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid_one_cycle", i), 32'(bus.valid), 32'd0);
      check($sformatf("vec%0d_result_held", i), bus.result, vecs[i].exp);
    end

    // Flush ten cycles into a DIV: no valid, busy drops next cycle.
    @(negedge clk);
    bus.op = DIV_OP; bus.dividend = 32'd1000; bus.divisor = 32'd7; bus.tag_in = 4'd1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("flush_busy_after_accept", 32'(bus.busy), 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk) bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush_busy_low", 32'(bus.busy), 32'd0);
    check("flush_valid_low", 32'(bus.valid), 32'd0);
    expect_no_valid("flush_no_valid", 40);
    run_op(DIVU_OP, 32'd9, 32'd3, 4'd2, res, tg, lat);
    check("post_flush_latency", 32'(lat), 32'(NORMAL_LAT));
    check("post_flush_result", res, 32'd3);
    check("post_flush_tag", 32'(tg), 32'd2);

    // start together with flush is ignored.
    @(negedge clk);
    bus.op = DIVU_OP; bus.dividend = 32'd8; bus.divisor = 32'd2; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
    check("start_with_flush_busy", 32'(bus.busy), 32'd0);
    expect_no_valid("start_with_flush_no_valid", 40);

    // Reset asserted mid-CALC.
    @(negedge clk);
    bus.op = DIVU_OP; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.tag_in = 4'd5; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_busy",    32'(bus.busy),    32'd0);
    check("midrst_valid",   32'(bus.valid),   32'd0);
    check("midrst_result",  bus.result,       32'd0);
    check("midrst_tag_out", 32'(bus.tag_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    expect_no_valid("midrst_no_valid", 40);

    // start while busy is ignored.
    @(negedge clk);
    bus.op = DIVU_OP; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.tag_in = 4'd3; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.op = REMU_OP; bus.dividend = 32'd50; bus.divisor = 32'd5; bus.tag_in = 4'd9; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1; res = '0; tg = '0;
    for (int k = 4; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        lat = k; res = bus.result; tg = bus.tag_out;
        break;
      end
    end
    check("busy_start_latency", 32'(lat), 32'(NORMAL_LAT));
    check("busy_start_result", res, 32'd14);
    check("busy_start_tag", 32'(tg), 32'd3);
    held = bus.result;
    expect_no_valid("busy_start_no_second_valid", 40);
    check("busy_start_result_held", bus.result, 32'd14);
    check("busy_start_result_stable", bus.result, held);

    // Random sweep, back-to-back issue.
    for (int n = 0; n < 1200; n++) begin
      op_e         op;
      logic [31:0] a, b;
      logic [3:0]  tag;
      op  = op_e'($urandom_range(0, 3));
      tag = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      run_op(op, a, b, tag, res, tg, lat);
      check($sformatf("rand%0d_op%0d_%h_%h_result", n, op, a, b), res, ref_model(op, a, b));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_lat(op, a, b)));
      check($sformatf("rand%0d_tag", n), 32'(tg), 32'(tag));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
